// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button event front end.
// Optional feature macro: BTN_AUTOREPEAT_EN (per-channel auto-repeat events).
package btn_pkg;

    localparam int unsigned N_BTN_DEFAULT = 5;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StOffer = 1'b1
    } arb_state_e;

    // Width of the button index; never below one bit.
    function automatic int unsigned id_w(int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must reach n-1; never below one bit.
    function automatic int unsigned cnt_w(int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter and press strobe.
// With BTN_AUTOREPEAT_EN defined a repeat counter adds periodic strobes while held.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned REP_DELAY  = 20,
    parameter int unsigned REP_PERIOD = 8
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic evt_pulse
);

    localparam int unsigned           CNT_W    = cnt_w(DB_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;
    logic             sync_lvl;
    logic             accept;
    logic             press;

    assign sync_lvl = sync_q[1];
    // The level has differed for DB_CYCLES consecutive edges, including this one.
    assign accept   = (sync_lvl != stable_q) && (cnt_q == CNT_LAST);
    assign press    = accept && sync_lvl;
    assign stable   = stable_q;

    // Synchronize the raw level and accept it once it has stayed different long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_lvl == stable_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                stable_q <= sync_lvl;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned REP_W   = cnt_w(REP_MAX);

    logic [REP_W-1:0] rep_cnt_q;
    logic             rep_phase_q;  // 0: waiting for first repeat, 1: periodic
    logic [REP_W-1:0] rep_last;
    logic             rep_fire;

    assign rep_last  = rep_phase_q ? REP_W'(REP_PERIOD - 1) : REP_W'(REP_DELAY - 1);
    assign rep_fire  = stable_q && (rep_cnt_q == rep_last);
    assign evt_pulse = press | rep_fire;

    // Count held cycles; restart at every repeat and clear whenever released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else if (!stable_q) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b1;
        end else begin
            rep_cnt_q <= rep_cnt_q + REP_W'(1);
        end
    end
`else
    assign evt_pulse = press;
`endif

endmodule

// File: rtl/btn_event_arbiter.sv
// Push-button front end: per-channel debounce, pending press flags and a
// round-robin arbiter offering one event at a time over valid/ready.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat while a button is held).
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN      = N_BTN_DEFAULT,
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned REP_DELAY  = 50_000_000,
    parameter int unsigned REP_PERIOD = 10_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_BTN-1:0]          btn_raw,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [id_w(N_BTN)-1:0]    evt_id,
    output logic [N_BTN-1:0]          btn_level,
    output logic                      overrun
);

    localparam int unsigned ID_W = id_w(N_BTN);

    if (N_BTN < 2 || N_BTN > 8 || DB_CYCLES < 2 || REP_DELAY < 1 || REP_PERIOD < 1)
    begin : g_bad_param
        $error("btn_event_arbiter: illegal parameter set");
    end

    logic [N_BTN-1:0] evt_pulse;
    logic [N_BTN-1:0] pending_q;
    logic [N_BTN-1:0] pending_d;
    logic [N_BTN-1:0] grant_clr;
    logic             overrun_d;
    arb_state_e       state_q;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  win_idx;
    logic [ID_W-1:0]  cand;
    logic             win_found;
    logic             grant;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REP_DELAY (REP_DELAY),
            .REP_PERIOD(REP_PERIOD)
`endif
        ) u_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw      (btn_raw[i]),
            .stable   (btn_level[i]),
            .evt_pulse(evt_pulse[i])
        );
    end

    // First pending index at or after ptr, searching cyclically.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % N_BTN);
            if (!win_found && pending_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant when idle, or when the current offer is being taken this edge.
    always_comb begin
        grant     = win_found && ((state_q == StIdle) || evt_ready);
        ptr_nxt   = (win_idx == ID_W'(N_BTN - 1)) ? '0 : win_idx + ID_W'(1);
        grant_clr = grant ? (N_BTN'(1) << win_idx) : '0;
        // A new event on the bit being granted survives: set wins over clear.
        pending_d = (pending_q & ~grant_clr) | evt_pulse;
        overrun_d = |(pending_q & ~grant_clr & evt_pulse);
    end

    // Pending event flags and the coalescing pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            overrun   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun   <= overrun_d;
        end
    end

    // Arbiter FSM with registered offer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            ptr_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant) begin
                        evt_id    <= win_idx;
                        ptr_q     <= ptr_nxt;
                        evt_valid <= 1'b1;
                        state_q   <= StOffer;
                    end
                end
                StOffer: begin
                    if (evt_ready) begin
                        if (grant) begin
                            evt_id <= win_idx;
                            ptr_q  <= ptr_nxt;
                        end else begin
                            evt_valid <= 1'b0;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Self-checking bench for btn_event_arbiter (N_BTN=5, DB_CYCLES=4).
// Build with BTN_AUTOREPEAT_EN defined to also exercise auto-repeat.
module tb_btn_event_arbiter;

    localparam int NB  = 5;
    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [2:0]    evt_id;
    logic [NB-1:0] btn_level;
    logic          overrun;

    btn_event_arbiter #(
        .N_BTN     (NB),
        .DB_CYCLES (DB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .btn_level(btn_level),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle", nm, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // A button level counts once the synchronized (2-cycle delayed) raw level has
    // differed from the accepted level for DB consecutive cycles.
    logic [NB-1:0] m_s1, m_s2, m_stable, m_pend, m_ev;
    int            m_run[NB];
    int            m_held[NB];
    logic          m_valid, m_ovr;
    int            m_id, m_ptr;
    int            exp_q[$];
    int            cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_ev = '0;
            m_valid = 1'b0; m_ovr = 1'b0; m_id = 0; m_ptr = 0;
            for (int i = 0; i < NB; i++) begin
                m_run[i] = 0;
                m_held[i] = 0;
            end
            exp_q.delete();
        end else begin
            logic nl;
            bit   found;
            int   w;
            m_ev = '0;
            for (int i = 0; i < NB; i++) begin
                nl = m_stable[i];
                if (m_s2[i] != m_stable[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DB) begin
                    nl = m_s2[i];
                    m_run[i] = 0;
                    if (m_s2[i]) m_ev[i] = 1'b1;
                end
`ifdef BTN_AUTOREPEAT_EN
                if (m_stable[i]) begin
                    m_held[i]++;
                    if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0))
                        m_ev[i] = 1'b1;
                end
                if (!m_stable[i] && nl) m_held[i] = 0;
`endif
                m_stable[i] = nl;
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
            if (!m_valid || evt_ready) begin
                found = 0;
                w = 0;
                for (int k = 0; k < NB; k++) begin
                    if (!found && m_pend[(m_ptr + k) % NB]) begin
                        found = 1;
                        w = (m_ptr + k) % NB;
                    end
                end
                if (found) begin
                    m_pend[w] = 1'b0;
                    m_valid = 1'b1;
                    m_id = w;
                    m_ptr = (w + 1) % NB;
                    exp_q.push_back(w);
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_ovr = |(m_ev & m_pend);
            m_pend = m_pend | m_ev;
            cyc++;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int hs_id[$];
    int hs_cyc[$];
    int ovr_cnt = 0;
    int e;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", evt_valid, m_valid);
            if (m_valid) chk("offer_id", evt_id, m_id);
            chk("btn_level", btn_level, m_stable);
            chk("overrun", overrun, m_ovr);
            if (overrun === 1'b1) ovr_cnt++;
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                hs_id.push_back(int'(evt_id));
                hs_cyc.push_back(cyc);
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_id", evt_id, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Count rising edges until evt_valid is seen high (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (evt_valid !== 1'b1 && n < 40);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0, o0, sz;
        step(3);
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_level", btn_level, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        step(2);

        // Single press with latency count.
        evt_ready = 1'b1;
        btn_raw[2] = 1'b1;
        wait_valid(n);
        chk("press_latency", n, 7);
        chk("press_id", evt_id, 2);
        chk("press_level", btn_level[2], 1);
        step(1);
        chk("press_one_cycle", evt_valid, 0);
        btn_raw = '0;
        step(10);

        // Glitch shorter than the debounce window.
        s0 = hs_id.size();
        btn_raw[0] = 1'b1;
        step(3);
        btn_raw[0] = 1'b0;
        step(12);
        chk("glitch_events", hs_id.size() - s0, 0);
        chk("glitch_level", btn_level, 0);

        // Press button 1 so the pointer ends at 2.
        btn_raw[1] = 1'b1;
        step(12);
        btn_raw = '0;
        step(12);

        // Simultaneous presses on 1, 3, 4 with ptr=2.
        btn_raw = 5'b11010;
        step(15);
        sz = hs_id.size();
        chk("simul_count", sz >= 3, 1);
        if (sz >= 3) begin
            chk("simul_id0", hs_id[sz-3], 3);
            chk("simul_id1", hs_id[sz-2], 4);
            chk("simul_id2", hs_id[sz-1], 1);
            chk("simul_b2b", hs_cyc[sz-1] - hs_cyc[sz-3], 2);
        end
        btn_raw = '0;
        step(12);

        // Backpressure: offer held, second press pends, third coalesces.
        evt_ready = 1'b0;
        s0 = hs_id.size();
        o0 = ovr_cnt;
        btn_raw[0] = 1'b1; step(8);
        chk("bp_offer", evt_valid, 1);
        btn_raw[0] = 1'b0; step(8);
        btn_raw[0] = 1'b1; step(8);
        btn_raw[0] = 1'b0; step(8);
        btn_raw[0] = 1'b1; step(8);
        chk("bp_overrun_once", ovr_cnt - o0, 1);
        chk("bp_id_held", evt_id, 0);
        chk("bp_no_handshake", hs_id.size() - s0, 0);
        evt_ready = 1'b1;
        step(4);
        chk("bp_two_events", hs_id.size() - s0, 2);
        if (hs_id.size() - s0 == 2) begin
            chk("bp_ev0", hs_id[s0], 0);
            chk("bp_ev1", hs_id[s0+1], 0);
        end
        btn_raw = '0;
        step(12);

        // Reset in the middle of an offer with the button held.
        evt_ready = 1'b0;
        btn_raw[2] = 1'b1;
        wait_valid(n);
        chk("offer_before_reset", evt_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_drop_valid", evt_valid, 0);
        chk("reset_level", btn_level, 0);
        chk("reset_id", evt_id, 0);
        step(2);
        rst_n = 1'b1;
        wait_valid(n);
        chk("post_reset_latency", n, 7);
        chk("post_reset_id", evt_id, 2);
        evt_ready = 1'b1;
        step(1);
        btn_raw = '0;
        step(12);

`ifdef BTN_AUTOREPEAT_EN
        // Auto-repeat while held: press, +RD, then every RP.
        s0 = hs_id.size();
        btn_raw[3] = 1'b1;
        step(60);
        chk("rep_count", hs_id.size() >= s0 + 4, 1);
        if (hs_id.size() >= s0 + 4) begin
            chk("rep_id", hs_id[s0+3], 3);
            chk("rep_first_gap", hs_cyc[s0+1] - hs_cyc[s0], RD);
            chk("rep_gap1", hs_cyc[s0+2] - hs_cyc[s0+1], RP);
            chk("rep_gap2", hs_cyc[s0+3] - hs_cyc[s0+2], RP);
        end
        btn_raw = '0;
        step(12);
        s0 = hs_id.size();
        step(40);
        chk("rep_stop_after_release", hs_id.size() - s0, 0);
`endif

        // Randomized buttons and backpressure against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(7) == 0) btn_raw[b] = ~btn_raw[b];
            evt_ready = ($urandom_range(3) != 0);
            step(1);
        end

        btn_raw = '0;
        evt_ready = 1'b1;
        step(40);
        chk("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Front-end controller that sequences the board's push-button inputs into a single event stream. Each raw button is brought into the `clk` domain through a two-flop synchronizer, debounced, and rising-edge detected. Press events are queued per button and granted one at a time, round-robin, to the downstream mode/time-setting FSM over a valid/ready handshake.

## Interface
Parameters:
- `N_BTN`, default 5, number of button channels; legal range 2–8.
- `DB_CYCLES`, default 1_000_000, number of cycles the synchronized level must stay stable before it is accepted; minimum 2.
- `REP_DELAY`, default 50_000_000, cycles from the accepted press to the first auto-repeat event.
- `REP_PERIOD`, default 10_000_000, cycles between later auto-repeat events.

Ports:
- `clk`, input, 1, single system clock; all logic is on the rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `btn_raw`, input, `N_BTN`, asynchronous raw button levels; 1 means pressed.
- `evt_valid`, output, 1, an event is offered.
- `evt_ready`, input, 1, the consumer accepts the event on the current edge.
- `evt_id`, output, `ID_W` = clog2(`N_BTN`), index of the offered button.
- `btn_level`, output, `N_BTN`, debounced stable levels.
- `overrun`, output, 1, one-cycle pulse when an event coalesces into an already-pending event.

## Operation
- **Per channel:** 2-flop synchronizer feeding a debounce counter.
  - Counter clears whenever the synchronized level equals `stable`.
  - When the levels differ, the counter increments.
  - On the edge where the counter equals `DB_CYCLES-1` and the levels still differ: `stable` takes the synchronized level and the counter clears.
- **Press:** `stable` going 0→1 sets `pending[i]` on that same edge.
  - If `pending[i]` is already 1, `pending[i]` stays 1 and `overrun` pulses for one cycle.
  - Releases (1→0) generate no event.
- **Arbiter FSM:** states `IDLE` and `OFFER`; round-robin pointer `ptr`.
  - `IDLE`: if any `pending` bit is set, pick the first set index at or after `ptr`, cyclically. Register it into `evt_id`, clear that `pending` bit, set `ptr` to winner+1 mod `N_BTN`, and go to `OFFER`.
  - `OFFER`: `evt_valid`=1 and `evt_id` is held constant until `evt_ready`=1.
  - On handshake with other events pending, load the next winner the same edge and stay in `OFFER`, giving back-to-back events. Otherwise go to `IDLE`.
- **Simultaneous set and clear** of the same `pending` bit: set wins, so the new event is retained.
- **Reset mid-operation:** everything clears asynchronously and `evt_valid` drops immediately. A button held through reset produces one press event after debounce, because `stable` restarts at 0.

## Timing
- Reset values: `evt_valid`=0, `evt_id`=0, `btn_level`=0, `overrun`=0, `ptr`=0, state `IDLE`, all `pending`, `stable`, synchronizer flops and counters 0.
- Latency, with an idle arbiter: `evt_valid` rises after exactly `DB_CYCLES`+3 rising edges, counting from the first edge that samples the new raw level.
  - 2 edges: synchronizer.
  - `DB_CYCLES`−1 edges: debounce.
  - 1 edge: `stable` and `pending` update together.
  - 1 edge: grant.
- Handshake throughput: one event per cycle.
- `evt_valid` never deasserts without a handshake, except on reset.
- Glitch rejection: raw pulses shorter than `DB_CYCLES` synchronized cycles never change `btn_level`.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: each channel gets a repeat counter that runs while `stable`=1.
  - `pending[i]` is set `REP_DELAY` cycles after the accepted press, then every `REP_PERIOD` cycles while the button is held.
  - Coalescing and `overrun` rules apply to repeat events as well.
  - The counter clears when `stable`=0.
- Not defined: the repeat counters are absent, only press events exist, and `REP_DELAY`/`REP_PERIOD` are ignored.

## Structure
- Package `btn_pkg` holds:
  - the `N_BTN` default and the `ID_W` function (clog2);
  - the arbiter state enum (`IDLE`, `OFFER`);
  - the debounce counter width function, clog2(`DB_CYCLES`).
- Sub-module `btn_debounce`, one instance per channel.
  - Contains the synchronizer, the debounce counter, and the optional repeat counter.
  - Outputs `stable` and a one-cycle `event` strobe.
- The top level holds `pending`, the round-robin arbiter and the output register.

## Test plan
All scenarios run with `N_BTN`=5 and `DB_CYCLES`=4. Scenario 6 additionally uses `REP_DELAY`=20 and `REP_PERIOD`=8.
1. Single press: `btn_raw[2]` 0→1 and held, `evt_ready`=1 → `evt_valid` high for one cycle, 7 edges after first sampling, with `evt_id`=2 and `btn_level[2]`=1.
2. Glitch: `btn_raw[0]` high for 3 cycles → `btn_level` stays 0, no event.
3. Simultaneous: buttons 1, 3 and 4 accepted on the same edge, `ptr`=2, `evt_ready`=1 → back-to-back `evt_id` 3, 4, 1.
4. Backpressure and overrun: `evt_ready`=0, button 0 pressed, released after debounce, then pressed again.
   - `evt_id`=0 stays stable; second press: `pending[0]` stays set and `overrun` pulses once.
   - When `evt_ready` goes 1, exactly two events with id 0 follow: the held offer, then the coalesced pending event.
5. Reset mid-offer: `rst_n`=0 while `evt_valid`=1 and button held → `evt_valid` drops immediately. After release of reset, one new event for that button arrives 7 edges later.
6. `BTN_AUTOREPEAT_EN` build: button held → events at press, +20 cycles, then every 8 cycles; no events after release.
